// File: rtl/photon_fifo_merger_dbg_pkg.sv
// Shared encodings and helpers for the photon FIFO merger debug/deadlock-monitor blocks.
package photon_fifo_merger_dbg_pkg;

   // Which side of the FIFO a monitored port sits on; selects the stall polarity.
   typedef enum logic {
      DIR_CONSUMER = 1'b0,
      DIR_PRODUCER = 1'b1
   } dir_e;

   localparam int DEF_CNT_W    = 16;
   localparam int DEF_EV_CNT_W = 16;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // Channel index width, never narrower than one bit.
   function automatic int ch_width(input int n_ch);
      return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
   endfunction

endpackage

// File: rtl/photon_fifo_merger_axis_stall_counter.sv
// Per-channel saturating stall counter; raises a registered block flag after
// STALL_THRESH consecutive qualified stall cycles.
module photon_fifo_merger_axis_stall_counter #(
   parameter int STALL_THRESH = 1024,
   parameter int CNT_W        = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic stall_q,
   output logic block,
   output logic rise
);

   localparam logic [CNT_W-1:0] THRESH    = CNT_W'(STALL_THRESH);
   localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESH - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             block_next;

   // Any non-stall cycle restarts the count; a held stall saturates rather than wraps.
   always_comb begin
      cnt_next = '0;
      if (stall_q) begin
         cnt_next = (cnt >= THRESH) ? THRESH : cnt + CNT_W'(1);
      end
      block_next = stall_q & (cnt >= THRESH_M1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt   <= '0;
         block <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         block <= block_next;
      end
   end

   assign rise = block_next & ~block;

endmodule

// File: rtl/photon_fifo_merger_axis_block_detector.sv
// Taps valid/ready pairs around the photon FIFO merger, flags ports stalled too long,
// and keeps a sticky first-offender record plus a saturating block-event count.
module photon_fifo_merger_axis_block_detector
   import photon_fifo_merger_dbg_pkg::*;
#(
   parameter int              N_CH         = 4,
   parameter logic [N_CH-1:0] DIR_MASK     = 4'b0011,
   parameter int              STALL_THRESH = 1024,
   parameter int              CNT_W        = DEF_CNT_W,
   parameter int              EV_CNT_W     = DEF_EV_CNT_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_CH-1:0]           s_tvalid,
   input  logic [N_CH-1:0]           s_tready,
   input  logic                      inst_idle,
   input  logic                      clear,
   output logic [N_CH-1:0]           axis_block_sigs,
   output logic                      any_block,
   output logic                      block_sticky,
   output logic [ch_width(N_CH)-1:0] first_ch,
   output logic [EV_CNT_W-1:0]       stall_events
);

   localparam int FC_W = ch_width(N_CH);

   logic [N_CH-1:0] stall_q;
   logic [N_CH-1:0] rise;
   logic [FC_W-1:0] first_idx;
   logic            any_rise;
   logic            ev_rise;

   // Stall meaning on a tapped valid/ready pair: a producer port stalls when it offers
   // data that is not taken (FIFO full); a consumer port stalls when it is ready but no
   // data is offered (FIFO empty). Both low is an idle link, not a stall.
   always_comb begin
      stall_q = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (DIR_MASK[i] == DIR_PRODUCER) begin
            stall_q[i] = s_tvalid[i] & ~s_tready[i] & ~inst_idle;
         end else begin
            stall_q[i] = s_tready[i] & ~s_tvalid[i] & ~inst_idle;
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      photon_fifo_merger_axis_stall_counter #(
         .STALL_THRESH(STALL_THRESH),
         .CNT_W       (CNT_W)
      ) u_cnt (
         .clock  (clock),
         .reset  (reset),
         .stall_q(stall_q[g]),
         .block  (axis_block_sigs[g]),
         .rise   (rise[g])
      );
   end

   // Lowest rising channel wins: scan downward so the last assignment is the lowest.
   always_comb begin
      first_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (rise[i]) first_idx = FC_W'(i);
      end
   end

   assign any_block = |axis_block_sigs;
   assign any_rise  = |rise;
   // With every flag currently low, the next-cycle OR equals the OR of the rises.
   assign ev_rise   = any_rise & ~any_block;

   // A rise in the same cycle as clear re-arms the record immediately.
   always_ff @(posedge clock) begin
      if (reset) begin
         block_sticky <= 1'b0;
         first_ch     <= '0;
      end else if (any_rise && (!block_sticky || clear)) begin
         block_sticky <= 1'b1;
         first_ch     <= first_idx;
      end else if (clear) begin
         block_sticky <= 1'b0;
         first_ch     <= '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_events <= '0;
      end else if (clear) begin
         stall_events <= ev_rise ? EV_CNT_W'(1) : '0;
      end else if (ev_rise && (stall_events != '1)) begin
         stall_events <= stall_events + EV_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_photon_fifo_merger_axis_block_detector.sv
// Directed bench for the AXI-Stream block detector (STALL_THRESH=8, N_CH=4, DIR_MASK=0011).
module tb_photon_fifo_merger_axis_block_detector;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] s_tvalid;
   logic [3:0] s_tready;
   logic       inst_idle;
   logic       clear;

   logic [3:0]  blk;
   logic        any_blk;
   logic        sticky;
   logic [1:0]  first_ch;
   logic [15:0] events;

   logic [3:0]  blk2;
   logic        any_blk2;
   logic        sticky2;
   logic [1:0]  first_ch2;
   logic [1:0]  events2;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   photon_fifo_merger_axis_block_detector #(
      .N_CH(4), .DIR_MASK(4'b0011), .STALL_THRESH(8), .CNT_W(16), .EV_CNT_W(16)
   ) dut (
      .clock(clock), .reset(reset), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .inst_idle(inst_idle), .clear(clear), .axis_block_sigs(blk), .any_block(any_blk),
      .block_sticky(sticky), .first_ch(first_ch), .stall_events(events)
   );

   photon_fifo_merger_axis_block_detector #(
      .N_CH(4), .DIR_MASK(4'b0011), .STALL_THRESH(8), .CNT_W(16), .EV_CNT_W(2)
   ) dut_sat (
      .clock(clock), .reset(reset), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .inst_idle(inst_idle), .clear(clear), .axis_block_sigs(blk2), .any_block(any_blk2),
      .block_sticky(sticky2), .first_ch(first_ch2), .stall_events(events2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   task automatic ch0_episode();
      s_tvalid[0] = 1'b1;
      tick(8);
      s_tvalid[0] = 1'b0;
      tick(1);
   endtask

   initial begin
      reset     = 1'b1;
      s_tvalid  = '0;
      s_tready  = '0;
      inst_idle = 1'b0;
      clear     = 1'b0;
      tick(2);
      check("rst_blk", blk, 4'h0);
      check("rst_any", any_blk, 1'b0);
      check("rst_sticky", sticky, 1'b0);
      check("rst_first", first_ch, 2'd0);
      check("rst_events", events, 16'd0);
      reset = 1'b0;
      tick(1);

      // 1: producer ch0 stalled, block after exactly 8 stall cycles
      s_tvalid[0] = 1'b1;
      tick(7);
      check("t1_blk_early", blk, 4'h0);
      tick(1);
      check("t1_blk", blk, 4'h1);
      check("t1_any", any_blk, 1'b1);
      check("t1_sticky", sticky, 1'b1);
      check("t1_first", first_ch, 2'd0);
      check("t1_events", events, 16'd1);
      tick(4);
      check("t1_blk_hold", blk, 4'h1);
      s_tvalid[0] = 1'b0;
      tick(1);
      check("t1_blk_drop", blk, 4'h0);

      // 2: consumer ch2 with a gap cycle never reaches threshold
      pulse_clear();
      check("t2_clr_sticky", sticky, 1'b0);
      check("t2_clr_events", events, 16'd0);
      s_tready[2] = 1'b1;
      tick(7);
      s_tready[2] = 1'b0;
      tick(1);
      check("t2_blk_gap", blk, 4'h0);
      s_tready[2] = 1'b1;
      tick(7);
      check("t2_blk", blk, 4'h0);
      check("t2_events", events, 16'd0);
      s_tready[2] = 1'b0;
      tick(1);

      // 3: ch1 (producer) and ch3 (consumer) stall together
      s_tvalid[1] = 1'b1;
      s_tready[3] = 1'b1;
      tick(8);
      check("t3_blk", blk, 4'b1010);
      check("t3_first", first_ch, 2'd1);
      check("t3_events", events, 16'd1);
      tick(2);
      s_tvalid[1] = 1'b0;
      s_tready[3] = 1'b0;
      tick(1);
      check("t3_blk_drop", blk, 4'h0);

      // 4: inst_idle suppresses a live block, then detection restarts
      pulse_clear();
      s_tvalid[0] = 1'b1;
      tick(8);
      check("t4_blk", blk, 4'h1);
      check("t4_events1", events, 16'd1);
      inst_idle = 1'b1;
      tick(1);
      check("t4_idle_blk", blk, 4'h0);
      inst_idle = 1'b0;
      tick(7);
      check("t4_reblk_early", blk, 4'h0);
      tick(1);
      check("t4_reblk", blk, 4'h1);
      check("t4_events2", events, 16'd2);
      check("t4_first", first_ch, 2'd0);
      s_tvalid[0] = 1'b0;
      tick(1);

      // 5: clear coincides with a new rise on ch3; the set wins
      s_tready[3] = 1'b1;
      tick(7);
      check("t5_pre_sticky", sticky, 1'b1);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("t5_blk", blk, 4'h8);
      check("t5_sticky", sticky, 1'b1);
      check("t5_first", first_ch, 2'd3);
      check("t5_events", events, 16'd1);
      s_tready[3] = 1'b0;
      tick(1);

      // 6: saturating 2-bit event counter, then reset in the middle of a stall
      pulse_clear();
      check("t6_clr_events2", events2, 2'd0);
      for (int e = 0; e < 3; e++) ch0_episode();
      check("t6_events2_3", events2, 2'd3);
      for (int e = 0; e < 2; e++) ch0_episode();
      check("t6_events2_sat", events2, 2'd3);
      check("t6_events_5", events, 16'd5);
      s_tvalid[0] = 1'b1;
      tick(9);
      check("t6_blk_pre_rst", blk, 4'h1);
      reset = 1'b1;
      tick(1);
      check("t6_rst_blk", blk, 4'h0);
      check("t6_rst_any", any_blk, 1'b0);
      check("t6_rst_sticky", sticky, 1'b0);
      check("t6_rst_events", events, 16'd0);
      check("t6_rst_blk2", blk2, 4'h0);
      check("t6_rst_events2", events2, 2'd0);
      reset = 1'b0;
      tick(7);
      check("t6_restart_early", blk, 4'h0);
      tick(1);
      check("t6_restart_blk", blk, 4'h1);
      check("t6_restart_events", events, 16'd1);
      s_tvalid[0] = 1'b0;
      tick(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
